// File: rtl/sobel_pkg.sv
// sobel_pkg
//   Shared widths, FSM encodings and small helpers for the Sobel gradient
//   stage (sobel_grad_sqr) and its consumer root_sqr.
//   PIX_W  : input pixel width
//   GRAD_W : signed gradient width (holds +/-1020)
//   SQR_W  : width of the squared, scaled gradient handed to root_sqr
//   MAG_W  : magnitude width used by root_sqr
package sobel_pkg;

  localparam int PIX_W  = 8;
  localparam int GRAD_W = 11;
  localparam int SQR_W  = 17;
  localparam int MAG_W  = 11;

  // Frame-level FSM encodings (kept as plain constants for legacy tools).
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef logic [PIX_W-1:0] pix_t;

  // Zero-extend a pixel into the gradient arithmetic width.
  function automatic logic [GRAD_W-1:0] pix_ext(input pix_t p);
    return GRAD_W'(p);
  endfunction

  // Magnitude of a two's-complement gradient. The gradient never reaches
  // -2^(GRAD_W-1), so the result always fits one bit narrower.
  function automatic logic [GRAD_W-2:0] grad_mag(input logic [GRAD_W-1:0] g);
    logic [GRAD_W-1:0] m;
    m = g[GRAD_W-1] ? (~g + 1'b1) : g;
    return m[GRAD_W-2:0];
  endfunction

endpackage

// File: rtl/line_buffer.sv
// line_buffer
//   One line of pixel storage. Single read/write address; the read is
//   combinational from the array, the write lands on the clock edge, so a
//   read and write to the same address in one cycle returns the old data
//   (read-before-write). Contents are never reset.
// Ports
//   clk   in  rising-edge clock
//   we    in  write enable
//   addr  in  shared read/write address (column)
//   wdata in  data written at addr
//   rdata out data currently stored at addr
module line_buffer #(
  parameter int DEPTH = 320,
  parameter int W     = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sobel_grad_sqr.sv
// sobel_grad_sqr
//   Streaming 3x3 Sobel stage. Tracks raster position, keeps two line
//   buffers plus a 3x3 window, computes Gx/Gy, scales |G| by SCALE_SH and
//   outputs the registered squares. A pixel accepted on edge k produces its
//   result on edge k+3.
// Ports
//   clk        in  rising-edge clock
//   rst_n      in  asynchronous active-low reset
//   pix_in     in  unsigned greyscale pixel, raster order
//   pix_valid  in  pix_in sampled on an edge where this is high
//   sof        in  start of frame, qualified by pix_valid (pixel (0,0))
//   sqrx       out (|Gx|>>SCALE_SH)^2, zero-extended
//   sqry       out (|Gy|>>SCALE_SH)^2, zero-extended
//   out_valid  out sqrx/sqry valid this cycle
//   frame_done out pulse alongside the last output of a frame
module sobel_grad_sqr
  import sobel_pkg::*;
#(
  parameter int IMG_W    = 320,
  parameter int IMG_H    = 240,
  parameter int SCALE_SH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             sof,
  output logic [SQR_W-1:0] sqrx,
  output logic [SQR_W-1:0] sqry,
  output logic             out_valid,
  output logic             frame_done
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int ABS_W = GRAD_W - 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  // ---------------------------------------------------------------- control
  logic [1:0]       state_reg;
  logic [COL_W-1:0] col_reg;
  logic [ROW_W-1:0] row_reg;

  logic             accept;
  logic [COL_W-1:0] cur_col;
  logic [ROW_W-1:0] cur_row;
  logic             last_pix;
  logic             tap_valid;

  // sof overrides the tracked position, so a restart works from any state.
  always_comb begin
    accept    = pix_valid && (sof || (state_reg == ST_RUN));
    cur_col   = sof ? '0 : col_reg;
    cur_row   = sof ? '0 : row_reg;
    last_pix  = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
    tap_valid = accept && (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      col_reg   <= '0;
      row_reg   <= '0;
    end else if (accept) begin
      if (last_pix) begin
        state_reg <= ST_DONE;
        col_reg   <= '0;
        row_reg   <= '0;
      end else begin
        state_reg <= ST_RUN;
        if (cur_col == COL_LAST) begin
          col_reg <= '0;
          row_reg <= cur_row + 1'b1;
        end else begin
          col_reg <= cur_col + 1'b1;
          row_reg <= cur_row;
        end
      end
    end
  end

  // ----------------------------------------------------------- line buffers
  logic [PIX_W-1:0] lb0_rdata;
  logic [PIX_W-1:0] lb1_rdata;

  // lb0 holds the previous line, lb1 the line before that.
  line_buffer #(.DEPTH(IMG_W), .W(PIX_W), .AW(COL_W)) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (cur_col),
    .wdata (pix_in),
    .rdata (lb0_rdata)
  );

  line_buffer #(.DEPTH(IMG_W), .W(PIX_W), .AW(COL_W)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (cur_col),
    .wdata (lb0_rdata),
    .rdata (lb1_rdata)
  );

  // ----------------------------------------------------------------- window
  // win_row_reg[r] packs {c2, c1, c0}; r0 is the oldest line, c0 the oldest
  // column. Edge columns are never padded; gating on tap_valid hides them.
  logic [PIX_W-1:0]   col_in      [3];
  logic [3*PIX_W-1:0] win_row_reg [3];
  logic [PIX_W-1:0]   px          [3][3];

  always_comb begin
    col_in[0] = lb1_rdata;
    col_in[1] = lb0_rdata;
    col_in[2] = pix_in;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        win_row_reg[gi] <= '0;
      end else if (accept) begin
        win_row_reg[gi] <= {col_in[gi], win_row_reg[gi][3*PIX_W-1:PIX_W]};
      end
    end

    for (genvar gc = 0; gc < 3; gc++) begin : g_win_col
      assign px[gi][gc] = win_row_reg[gi][gc*PIX_W +: PIX_W];
    end
  end

  // --------------------------------------------------------------- datapath
  logic [GRAD_W-1:0] gx_comb;
  logic [GRAD_W-1:0] gy_comb;

  // Differences wrap naturally into two's complement at GRAD_W bits.
  always_comb begin
    gx_comb = (pix_ext(px[0][2]) + (pix_ext(px[1][2]) << 1) + pix_ext(px[2][2]))
            - (pix_ext(px[0][0]) + (pix_ext(px[1][0]) << 1) + pix_ext(px[2][0]));
    gy_comb = (pix_ext(px[2][0]) + (pix_ext(px[2][1]) << 1) + pix_ext(px[2][2]))
            - (pix_ext(px[0][0]) + (pix_ext(px[0][1]) << 1) + pix_ext(px[0][2]));
  end

  logic              v0_reg, v1_reg, v2_reg;
  logic              fd0_reg, fd1_reg, fd2_reg;
  logic [GRAD_W-1:0] gx_reg, gy_reg;
  logic [ABS_W-1:0]  ax_reg, ay_reg;
  logic [SQR_W-1:0]  sqrx_reg, sqry_reg;
  logic              out_valid_reg, frame_done_reg;

  logic [2*ABS_W-1:0] sqx_full;
  logic [2*ABS_W-1:0] sqy_full;

  assign sqx_full = (2*ABS_W)'(ax_reg) * (2*ABS_W)'(ax_reg);
  assign sqy_full = (2*ABS_W)'(ay_reg) * (2*ABS_W)'(ay_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_reg         <= 1'b0;
      v1_reg         <= 1'b0;
      v2_reg         <= 1'b0;
      fd0_reg        <= 1'b0;
      fd1_reg        <= 1'b0;
      fd2_reg        <= 1'b0;
      gx_reg         <= '0;
      gy_reg         <= '0;
      ax_reg         <= '0;
      ay_reg         <= '0;
      sqrx_reg       <= '0;
      sqry_reg       <= '0;
      out_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      // Stage 0 valid travels with the window update.
      v0_reg  <= tap_valid;
      fd0_reg <= tap_valid && last_pix;
      // Stage 1: gradients.
      v1_reg  <= v0_reg;
      fd1_reg <= fd0_reg;
      gx_reg  <= gx_comb;
      gy_reg  <= gy_comb;
      // Stage 2: scaled magnitudes.
      v2_reg  <= v1_reg;
      fd2_reg <= fd1_reg;
      ax_reg  <= grad_mag(gx_reg) >> SCALE_SH;
      ay_reg  <= grad_mag(gy_reg) >> SCALE_SH;
      // Stage 3: squares; outputs hold between valid results.
      out_valid_reg  <= v2_reg;
      frame_done_reg <= fd2_reg;
      if (v2_reg) begin
        sqrx_reg <= sqx_full[SQR_W-1:0];
        sqry_reg <= sqy_full[SQR_W-1:0];
      end
    end
  end

  assign sqrx       = sqrx_reg;
  assign sqry       = sqry_reg;
  assign out_valid  = out_valid_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_sobel_grad_sqr.sv
module tb_sobel_grad_sqr;

  localparam int W = 8;
  localparam int H = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  pix_in = '0;
  logic        pix_valid = 1'b0;
  logic        sof = 1'b0;
  logic [16:0] sqrx, sqry;
  logic        out_valid, frame_done;

  always #5 clk = ~clk;

  sobel_grad_sqr #(.IMG_W(W), .IMG_H(H), .SCALE_SH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .sof        (sof),
    .sqrx       (sqrx),
    .sqry       (sqry),
    .out_valid  (out_valid),
    .frame_done (frame_done)
  );

  typedef struct {
    int due;
    int sx;
    int sy;
    bit fd;
  } exp_t;

  exp_t q[$];
  int   img [H][W];
  int   cycle = 0;
  bit   running = 1'b0;
  int   m_row = 0, m_col = 0;
  int   n_asserts = 0, n_fail = 0;
  int   outs_seen = 0, fd_seen = 0, x_full = 0, y_full = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sq_of(input int g);
    int a;
    a = ((g < 0) ? -g : g) >> 2;
    return a * a;
  endfunction

  // Expected result for an output centred at (cr, cc), straight from the image.
  task automatic push_expected(input int cr, input int cc, input int due, input bit fd);
    int gx, gy;
    exp_t e;
    gx = (img[cr-1][cc+1] + 2*img[cr][cc+1] + img[cr+1][cc+1])
       - (img[cr-1][cc-1] + 2*img[cr][cc-1] + img[cr+1][cc-1]);
    gy = (img[cr+1][cc-1] + 2*img[cr+1][cc] + img[cr+1][cc+1])
       - (img[cr-1][cc-1] + 2*img[cr-1][cc] + img[cr-1][cc+1]);
    e.due = due;
    e.sx  = sq_of(gx);
    e.sy  = sq_of(gy);
    e.fd  = fd;
    q.push_back(e);
  endtask

  // One clock: drive inputs, update the position model, sample after the edge.
  task automatic tick(input logic [7:0] p, input bit v, input bit s);
    int r, c;
    exp_t e;
    pix_in    = p;
    pix_valid = v;
    sof       = s;
    if (v && (s || running)) begin
      r = s ? 0 : m_row;
      c = s ? 0 : m_col;
      if (r >= 2 && c >= 2) push_expected(r - 1, c - 1, cycle + 4, (r == H-1) && (c == W-1));
      if (r == H-1 && c == W-1) begin
        running = 1'b0;
        m_row = 0;
        m_col = 0;
      end else begin
        running = 1'b1;
        if (c == W-1) begin
          m_col = 0;
          m_row = r + 1;
        end else begin
          m_col = c + 1;
          m_row = r;
        end
      end
    end
    @(posedge clk);
    cycle++;
    #1;
    if (out_valid === 1'b1) begin
      outs_seen++;
      if (sqrx === 17'd65025) x_full++;
      if (sqry === 17'd65025) y_full++;
    end
    if (frame_done === 1'b1) fd_seen++;
    if (q.size() > 0 && q[0].due == cycle) begin
      e = q.pop_front();
      check("out_valid", 32'(out_valid), 32'd1);
      check("sqrx", 32'(sqrx), 32'(e.sx));
      check("sqry", 32'(sqry), 32'(e.sy));
      check("frame_done", 32'(frame_done), 32'(e.fd));
      $display("cycle %0d: out sqrx=%0d sqry=%0d fd=%0b", cycle, sqrx, sqry, frame_done);
    end else begin
      check("out_valid_idle", 32'(out_valid), 32'd0);
      check("frame_done_idle", 32'(frame_done), 32'd0);
    end
  endtask

  task automatic send_frame(input int n_pix, input int gap_pct);
    int r, c;
    for (int i = 0; i < n_pix; i++) begin
      r = i / W;
      c = i % W;
      if (gap_pct > 0) begin
        while ($urandom_range(0, 99) < gap_pct) tick(8'($urandom_range(0, 255)), 1'b0, 1'b0);
      end
      tick(8'(img[r][c]), 1'b1, i == 0);
    end
  endtask

  task automatic drain();
    repeat (6) tick(8'd0, 1'b0, 1'b0);
  endtask

  task automatic clear_counts();
    outs_seen = 0;
    fd_seen   = 0;
    x_full    = 0;
    y_full    = 0;
  endtask

  initial begin
    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_sqrx", 32'(sqrx), 32'd0);
    check("rst_sqry", 32'(sqry), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drain();

    // 1: flat frame.
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 128;
    clear_counts();
    send_frame(W*H, 0);
    drain();
    check("flat_count", 32'(outs_seen), 32'd24);
    check("flat_fd", 32'(fd_seen), 32'd1);

    // Pixels without sof after DONE are dropped.
    clear_counts();
    repeat (12) tick(8'd200, 1'b1, 1'b0);
    drain();
    check("done_drop", 32'(outs_seen), 32'd0);

    // 2: vertical step.
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c < 4) ? 0 : 255;
    clear_counts();
    send_frame(W*H, 0);
    drain();
    check("vstep_count", 32'(outs_seen), 32'd24);
    check("vstep_xfull", 32'(x_full), 32'd8);
    check("vstep_yfull", 32'(y_full), 32'd0);

    // 3: horizontal step.
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (r < 3) ? 0 : 255;
    clear_counts();
    send_frame(W*H, 0);
    drain();
    check("hstep_count", 32'(outs_seen), 32'd24);
    check("hstep_yfull", 32'(y_full), 32'd12);
    check("hstep_xfull", 32'(x_full), 32'd0);

    // 4: random frame with pix_valid gaps.
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = $urandom_range(0, 255);
    clear_counts();
    send_frame(W*H, 35);
    drain();
    check("gap_count", 32'(outs_seen), 32'd24);
    check("gap_fd", 32'(fd_seen), 32'd1);

    // 5: restart at row 3 col 4; 6 + 2 old outputs drain plus 24 new ones.
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = $urandom_range(0, 255);
    clear_counts();
    send_frame(3*W + 4, 0);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = $urandom_range(0, 255);
    send_frame(W*H, 0);
    drain();
    check("restart_count", 32'(outs_seen), 32'd32);
    check("restart_fd", 32'(fd_seen), 32'd1);

    // 6: reset pulse mid-frame while outputs are in flight.
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = $urandom_range(0, 255);
    send_frame(4*W + 4, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_frame_done", 32'(frame_done), 32'd0);
    q.delete();
    running = 1'b0;
    m_row = 0;
    m_col = 0;
    tick(8'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    clear_counts();
    repeat (12) tick(8'd77, 1'b1, 1'b0);
    drain();
    check("post_rst_drop", 32'(outs_seen), 32'd0);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = $urandom_range(0, 255);
    clear_counts();
    send_frame(W*H, 0);
    drain();
    check("post_rst_count", 32'(outs_seen), 32'd24);
    check("post_rst_fd", 32'(fd_seen), 32'd1);

    check("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
